// File: rtl/risc_pkg.sv
// Shared definitions for the pipeline control blocks: opcodes, instruction
// field positions, the canonical NOP word and the LM/SM sequencer state type.
package risc_pkg;

  localparam logic [3:0] OPC_LW = 4'b0100;
  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  // Instruction field slice positions within the 16-bit word.
  localparam int IW_OPC_HI  = 15;
  localparam int IW_OPC_LO  = 12;
  localparam int IW_RA_HI   = 11;
  localparam int IW_RA_LO   = 9;
  localparam int IW_RB_HI   = 8;
  localparam int IW_RB_LO   = 6;
  localparam int IW_LIST_HI = 7;
  localparam int IW_LIST_LO = 0;

  localparam logic [15:0] NOP_IW = 16'hfffe;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/lsb_onehot_enc.sv
// Lowest-set-bit encoder for an 8-bit register list, plus a flag that is
// high when exactly one bit is set (i.e. the current micro-op is the last).
module lsb_onehot_enc (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       one
);

  // Scan from the top down so the lowest set bit wins; idx is 0 for vec==0.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = i[2:0];
    end
  end

  // Clearing the lowest bit leaves zero only when a single bit was set.
  always_comb begin
    one = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID stall and validity control: load-use hazards, fetch redirects and
// the LM/SM register-list sequencer that expands one instruction into one
// micro-op per set list bit.
//
// Handshake: there is no valid/ready pair here. stall_IF/stall_pc hold the
// IF/ID register and PC for the cycle they are high; valid_IF_ID is the
// validity written into IF/ID (0 inserts a bubble); valid_ID_RR qualifies
// the op leaving ID in the same cycle. All outputs are combinational from
// registered state and current inputs.
module ifid_hazard_ctrl
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] id_iw,
  input  logic        id_valid,
  input  logic        rr_load_valid,
  input  logic [2:0]  rr_load_dest,
  input  logic        ex_redirect,
  input  logic        id_redirect,
  output logic        stall_IF,
  output logic        stall_pc,
  output logic        valid_IF_ID,
  output logic        valid_ID_RR,
  output logic        uop_valid,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_offset,
  output logic        uop_last,
  output logic        busy,
  output seq_state_t  dbg_state
);

  seq_state_t state, state_nxt;
  logic [7:0] mask, mask_nxt;
  logic [2:0] offset, offset_nxt;

  logic [3:0] opc;
  logic [2:0] ra, rb;
  logic [7:0] list, cur;
  logic       is_lmsm, load_use;
  logic [2:0] enc_idx;
  logic       enc_one;

  assign opc  = id_iw[IW_OPC_HI:IW_OPC_LO];
  assign ra   = id_iw[IW_RA_HI:IW_RA_LO];
  assign rb   = id_iw[IW_RB_HI:IW_RB_LO];
  assign list = id_iw[IW_LIST_HI:IW_LIST_LO];

  assign is_lmsm  = id_valid && ((opc == OPC_LM) || (opc == OPC_SM));
  assign load_use = rr_load_valid && id_valid &&
                    ((rr_load_dest == ra) || (rr_load_dest == rb));

  // The list comes straight from the instruction on the first cycle so the
  // first micro-op needs no extra latency; afterwards the remaining mask.
  assign cur = (state == ST_SEQ) ? mask : list;

  lsb_onehot_enc u_enc (
    .vec (cur),
    .idx (enc_idx),
    .one (enc_one)
  );

  // Output decode and next-state selection in priority order.
  always_comb begin
    stall_IF    = 1'b0;
    stall_pc    = 1'b0;
    valid_IF_ID = 1'b1;
    valid_ID_RR = id_valid;
    uop_valid   = 1'b0;
    uop_reg     = enc_idx;
    uop_offset  = 3'd0;
    uop_last    = enc_one;
    busy        = (state == ST_SEQ);
    dbg_state   = state;
    state_nxt   = state;
    mask_nxt    = mask;
    offset_nxt  = offset;

    if (reset) begin
      valid_IF_ID = 1'b0;
      valid_ID_RR = 1'b0;
      uop_reg     = 3'd0;
      uop_last    = 1'b0;
      busy        = 1'b0;
      dbg_state   = ST_IDLE;
    end else if (ex_redirect) begin
      // Abort: flush both stages and drop any remaining micro-ops.
      valid_IF_ID = 1'b0;
      valid_ID_RR = 1'b0;
      state_nxt   = ST_IDLE;
      mask_nxt    = 8'd0;
      offset_nxt  = 3'd0;
    end else if (load_use) begin
      // Freeze everything; sequencer state is left untouched.
      stall_IF    = 1'b1;
      stall_pc    = 1'b1;
      valid_ID_RR = 1'b0;
    end else if (state == ST_SEQ) begin
      uop_valid  = 1'b1;
      uop_offset = offset;
      mask_nxt   = mask & (mask - 8'd1);
      if (enc_one) begin
        state_nxt  = ST_IDLE;
        offset_nxt = 3'd0;
      end else begin
        stall_IF   = 1'b1;
        stall_pc   = 1'b1;
        offset_nxt = offset + 3'd1;
      end
    end else if (is_lmsm) begin
      if (list == 8'd0) begin
        valid_ID_RR = 1'b0;
      end else begin
        uop_valid = 1'b1;
        if (!enc_one) begin
          stall_IF   = 1'b1;
          stall_pc   = 1'b1;
          mask_nxt   = list & (list - 8'd1);
          offset_nxt = 3'd1;
          state_nxt  = ST_SEQ;
        end
      end
    end else if (id_redirect) begin
      valid_IF_ID = 1'b0;
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mask   <= 8'd0;
      offset <= 3'd0;
    end else begin
      state  <= state_nxt;
      mask   <= mask_nxt;
      offset <= offset_nxt;
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ifid_hazard_ctrl;
  import risc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] id_iw;
  logic        id_valid;
  logic        rr_load_valid;
  logic [2:0]  rr_load_dest;
  logic        ex_redirect;
  logic        id_redirect;
  logic        stall_IF, stall_pc, valid_IF_ID, valid_ID_RR;
  logic        uop_valid, uop_last, busy;
  logic [2:0]  uop_reg, uop_offset;
  seq_state_t  dbg_state;

  ifid_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_iw         (id_iw),
    .id_valid      (id_valid),
    .rr_load_valid (rr_load_valid),
    .rr_load_dest  (rr_load_dest),
    .ex_redirect   (ex_redirect),
    .id_redirect   (id_redirect),
    .stall_IF      (stall_IF),
    .stall_pc      (stall_pc),
    .valid_IF_ID   (valid_IF_ID),
    .valid_ID_RR   (valid_ID_RR),
    .uop_valid     (uop_valid),
    .uop_reg       (uop_reg),
    .uop_offset    (uop_offset),
    .uop_last      (uop_last),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  int uop_seen = 0;

  // Reference model: a sequence in progress is a queue of the register
  // indices still to be issued plus the next word offset.
  bit       m_seq = 1'b0;
  int       m_rem[$];
  int       m_off = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate one cycle: compare outputs with the model, then clock it.
  task automatic step();
    logic e_stall, e_vif, e_vrr, e_uv, e_last, e_busy;
    int   e_reg, e_off;
    bit   n_seq;
    int   n_rem[$];
    int   n_off;
    int   lst[$];
    logic [7:0] l;
    logic [3:0] op;
    bit   lu, lmsm;

    #2;
    op   = id_iw[15:12];
    l    = id_iw[7:0];
    lu   = rr_load_valid && id_valid &&
           (rr_load_dest == id_iw[11:9] || rr_load_dest == id_iw[8:6]);
    lmsm = id_valid && (op == 4'd6 || op == 4'd7);
    e_stall = 0; e_vif = 1; e_vrr = id_valid; e_uv = 0; e_last = 0;
    e_reg = 0; e_off = 0; e_busy = m_seq;
    n_seq = m_seq; n_rem = m_rem; n_off = m_off;

    if (reset) begin
      e_vif = 0; e_vrr = 0; e_busy = 0;
      n_seq = 0; n_rem.delete(); n_off = 0;
    end else if (ex_redirect) begin
      e_vif = 0; e_vrr = 0;
      n_seq = 0; n_rem.delete(); n_off = 0;
    end else if (lu) begin
      e_stall = 1; e_vrr = 0;
    end else if (m_seq) begin
      e_uv = 1; e_reg = m_rem[0]; e_off = m_off;
      e_last = (m_rem.size() == 1);
      e_stall = !e_last;
      void'(n_rem.pop_front());
      n_off = m_off + 1;
      if (n_rem.size() == 0) begin n_seq = 0; n_off = 0; end
    end else if (lmsm) begin
      for (int b = 0; b < 8; b++) if (l[b]) lst.push_back(b);
      if (lst.size() == 0) begin
        e_vrr = 0;
      end else begin
        e_uv = 1; e_reg = lst[0]; e_off = 0;
        e_last = (lst.size() == 1);
        if (!e_last) begin
          e_stall = 1;
          void'(lst.pop_front());
          n_rem = lst; n_off = 1; n_seq = 1;
        end
      end
    end else if (id_redirect) begin
      e_vif = 0;
    end

    chk("stall_IF",    {7'd0, stall_IF},    {7'd0, e_stall});
    chk("stall_pc",    {7'd0, stall_pc},    {7'd0, e_stall});
    chk("valid_IF_ID", {7'd0, valid_IF_ID}, {7'd0, e_vif});
    chk("valid_ID_RR", {7'd0, valid_ID_RR}, {7'd0, e_vrr});
    chk("uop_valid",   {7'd0, uop_valid},   {7'd0, e_uv});
    chk("busy",        {7'd0, busy},        {7'd0, e_busy});
    chk("dbg_state",   {7'd0, dbg_state == ST_SEQ}, {7'd0, e_busy});
    if (e_uv) begin
      chk("uop_reg",    {5'd0, uop_reg},    8'(e_reg));
      chk("uop_offset", {5'd0, uop_offset}, 8'(e_off));
      chk("uop_last",   {7'd0, uop_last},   {7'd0, e_last});
    end
    if (reset) begin
      chk("rst_uop_reg",  {5'd0, uop_reg},  8'd0);
      chk("rst_uop_last", {7'd0, uop_last}, 8'd0);
    end
    if (uop_valid) uop_seen++;

    @(posedge clk);
    m_seq = n_seq; m_rem = n_rem; m_off = n_off;
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [15:0] iw, input logic v,
                       input logic lv, input logic [2:0] ld,
                       input logic ex, input logic idr);
    reset = r; id_iw = iw; id_valid = v; rr_load_valid = lv;
    rr_load_dest = ld; ex_redirect = ex; id_redirect = idr;
    step();
  endtask

  localparam logic [15:0] ADD_R1_R3 = {4'h0, 3'd1, 3'd3, 6'd0};

  initial begin
    logic [15:0] iw;
    reset = 1; id_iw = NOP_IW; id_valid = 0; rr_load_valid = 0;
    rr_load_dest = 0; ex_redirect = 0; id_redirect = 0;
    @(posedge clk); #1;

    // Reset state
    drive(1, NOP_IW, 0, 0, 0, 0, 0);
    drive(1, NOP_IW, 1, 0, 0, 0, 0);

    // LM with three registers: reg1/off0, reg5/off1, reg7/off2 last
    uop_seen = 0;
    for (int k = 0; k < 3; k++) drive(0, {4'h6, 4'h0, 8'b1010_0010}, 1, 0, 0, 0, 0);
    chk("lm3_uop_count", 8'(uop_seen), 8'd3);
    drive(0, NOP_IW, 1, 0, 0, 0, 0);

    // Load-use on rb, then normal
    drive(0, ADD_R1_R3, 1, 1, 3'd3, 0, 0);
    drive(0, ADD_R1_R3, 1, 0, 3'd3, 0, 0);

    // SM 0xFF with ex_redirect in its third cycle
    uop_seen = 0;
    drive(0, {4'h7, 4'h0, 8'hFF}, 1, 0, 0, 0, 0);
    drive(0, {4'h7, 4'h0, 8'hFF}, 1, 0, 0, 0, 0);
    drive(0, {4'h7, 4'h0, 8'hFF}, 1, 0, 0, 1, 0);
    drive(0, NOP_IW, 0, 0, 0, 0, 0);
    chk("redirect_uop_count", 8'(uop_seen), 8'd2);

    // Empty list
    drive(0, {4'h6, 4'h2, 8'h00}, 1, 0, 0, 0, 0);

    // JAL redirect with load-use: load-use wins, then redirect alone
    drive(0, ADD_R1_R3, 1, 1, 3'd3, 0, 1);
    drive(0, ADD_R1_R3, 1, 0, 3'd3, 0, 1);
    drive(0, ADD_R1_R3, 1, 0, 3'd3, 0, 0);

    // Load-use mid-sequence stretches it without losing micro-ops
    uop_seen = 0;
    iw = {4'h6, 4'h0, 8'b0100_1001};   // ra=0, rb=1
    drive(0, iw, 1, 0, 0, 0, 0);
    drive(0, iw, 1, 1, 3'd1, 0, 0);
    drive(0, iw, 1, 0, 0, 0, 0);
    drive(0, iw, 1, 0, 0, 0, 0);
    chk("lu_seq_uop_count", 8'(uop_seen), 8'd3);

    // Reset at SEQ offset 4, then a fresh LM starts at offset 0
    for (int k = 0; k < 4; k++) drive(0, {4'h6, 4'h0, 8'hFF}, 1, 0, 0, 0, 0);
    drive(1, {4'h6, 4'h0, 8'hFF}, 1, 0, 0, 0, 0);
    drive(0, {4'h6, 4'h0, 8'h06}, 1, 0, 0, 0, 0);
    drive(0, {4'h6, 4'h0, 8'h06}, 1, 0, 0, 0, 0);

    // Random traffic
    iw = NOP_IW;
    for (int n = 0; n < 400; n++) begin
      logic v;
      v = 1'b1;
      if (!m_seq) begin
        case ($urandom_range(0, 3))
          0: iw = {4'h6, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
          1: iw = {4'h7, 4'($urandom_range(0, 15)),
                   8'(1 << $urandom_range(0, 7)) | 8'($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(0, 255)))};
          default: iw = 16'($urandom_range(0, 65535));
        endcase
        v = ($urandom_range(0, 7) != 0);
      end
      drive($urandom_range(0, 63) == 0, iw, v,
            $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_ctrl.md
# ifid_hazard_ctrl

Pipeline control unit for the IF/ID stage register and the ID→RR handoff. Generates the IF/ID stall and validity controls from three sources: load-use hazards, branch/jump redirects, and the multi-cycle LM/SM register-list sequencer. The LM/SM sequencer expands one LM/SM instruction held in ID into one micro-op per set register bit. Sits beside the IF/ID register and drives its `stall_IF` and `in_Validity_IF_ID` inputs.

## Interface
- `OPC_LM`, 4'b0110: LM opcode, `iw[15:12]`.
- `OPC_SM`, 4'b0111: SM opcode.
- `OPC_LW`, 4'b0100: load opcode; used only for documentation of `rr_load_valid` producers.
- `clk` in 1: single clock; state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `id_iw` in 16: instruction word currently held in IF/ID.
- `id_valid` in 1: IF/ID validity output.
- `rr_load_valid` in 1: instruction in RR is a valid load.
- `rr_load_dest` in 3: destination register of that load.
- `ex_redirect` in 1: EX resolved a mispredict or indirect jump; fetch is redirected.
- `id_redirect` in 1: ID resolved a JAL; fetch is redirected.
- `stall_IF` out 1: hold IF/ID contents.
- `stall_pc` out 1: hold PC.
- `valid_IF_ID` out 1: validity presented to IF/ID (0 = bubble/flush).
- `valid_ID_RR` out 1: validity of the op leaving ID toward RR.
- `uop_valid` out 1: current ID output is an LM/SM micro-op.
- `uop_reg` out 3: register index of the current micro-op.
- `uop_offset` out 3: word offset from the base for the current micro-op.
- `uop_last` out 1: current micro-op is the final one.
- `busy` out 1: sequencer in SEQ state.

## Operation
- Decode from `id_iw`: `opc=[15:12]`, `ra=[11:9]`, `rb=[8:6]`, `list=[7:0]`. Bit i of `list` selects Ri.
- Sources are LM/SM-independent: ALU-type ops use ra and rb; loads and stores use ra and rb. A load-use hazard is `rr_load_valid & id_valid & (rr_load_dest==ra | rr_load_dest==rb)`.
- Priority, highest first: reset, `ex_redirect`, load-use, LM/SM sequencing, `id_redirect`.
- `ex_redirect`:
  - `valid_IF_ID=0`, `valid_ID_RR=0`, `stall_IF=0`, `stall_pc=0`.
  - FSM forced to IDLE and mask cleared in the same edge.
- Load-use:
  - `stall_IF=1`, `stall_pc=1`, `valid_ID_RR=0`.
  - FSM state, mask and offset are frozen.
  - `valid_IF_ID` is 1.
- FSM states are IDLE and SEQ. Registers are `mask[7:0]` and `offset[2:0]`.
  - Let `cur` = `list` in IDLE, else `mask`.
  - `uop_reg` is the index of the lowest set bit of `cur`.
  - `uop_last` = `cur` has exactly one set bit.
- IDLE with valid LM/SM and nonzero `list`:
  - Emit the micro-op for the lowest bit with offset 0.
  - If not last: `mask<=list` with lowest bit cleared, `offset<=1`, go to SEQ, assert `stall_IF`/`stall_pc`.
  - If last: stay IDLE, no stall.
- SEQ:
  - Emit the micro-op with `uop_offset=offset` and clear the lowest bit.
  - `offset<=offset+1`; 3-bit, max value 7, never wraps because the list has at most 8 bits.
  - Stall while not last; on last return to IDLE with stall deasserted that cycle.
- LM/SM with `list==0`: `valid_ID_RR=0` (instruction retires as NOP), no stall, stay IDLE.
- `id_redirect`, when no higher source is active: `valid_IF_ID=0` for one cycle; `valid_ID_RR` unaffected.
- Otherwise: `valid_IF_ID=1`, `valid_ID_RR=id_valid`, no stalls, `uop_valid=0`.

## Timing
- All outputs are combinational from registered state and inputs, stable before the IF/ID falling-edge capture.
- Reset values: state IDLE, `mask=0`, `offset=0`. While `reset=1`, all outputs are 0.
- An N-bit list occupies ID for N cycles. `stall_IF` is high for N-1 cycles. Zero-latency start: the first micro-op is emitted in the cycle the LM/SM appears.
- A load-use hazard in SEQ extends the sequence by one cycle per stalled cycle; no micro-op is lost or duplicated.
- `ex_redirect` mid-sequence aborts immediately. Micro-ops already emitted stand; no further micro-ops are emitted.
- Reset mid-SEQ returns to IDLE at the next rising edge.

## Structure
- Shared package `risc_pkg`: opcode constants, the field-slice positions, and a `NOP_IW`=16'hfffe constant.
- One sub-module `lsb_onehot_enc` (8-bit lowest-set-bit index plus single-bit detect), used for `uop_reg`/`uop_last`.

## Test plan
- **LM, 3 registers:** LM with `list=8'b1010_0010`, no hazards → micro-ops (reg1,off0), (reg5,off1), (reg7,off2,last). `stall_IF`=1,1,0. `busy` high for 2 cycles.
- **Load-use:** `rr_load_valid=1`, `rr_load_dest=3`, `id_iw` ADD with rb=3 → `stall_IF=1`, `stall_pc=1`, `valid_ID_RR=0` for 1 cycle, then normal.
- **Redirect mid-sequence:** SM with `list=8'hFF`, `ex_redirect` in its 3rd cycle → `valid_IF_ID=0`, `valid_ID_RR=0`, `busy=0` next cycle; exactly 2 micro-ops emitted.
- **Empty list:** LM with `list=8'h00` → `valid_ID_RR=0`, `uop_valid=0`, no stall.
- **Priority with JAL:** `id_redirect` together with a load-use hazard → load-use wins (stall, no flush). Next cycle `id_redirect` alone → `valid_IF_ID=0` for 1 cycle.
- **Reset mid-SEQ:** `reset=1` at SEQ offset 4 → all outputs 0; IDLE, `mask=0`, `offset=0` after the edge.
